// File: rtl/soc_event_async_src.sv
// soc_event_async_src: multi-channel write half of the SoC-to-cluster async event FIFO
module soc_event_async_src #(
   parameter int  EVNT_WIDTH   = 8,
   parameter int  LOG_DEPTH    = 3,
   parameter int  N_CH         = 4,
   parameter int  SYNC_STAGES  = 2,
   parameter bit  DROP_ON_FULL = 1'b0,
   localparam int CH_IDW       = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int DW           = EVNT_WIDTH + CH_IDW
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [N_CH-1:0]                     evt_valid_i,
   input  logic [N_CH-1:0][EVNT_WIDTH-1:0]     evt_data_i,
   output logic [N_CH-1:0]                     evt_ready_o,
   output logic [LOG_DEPTH:0]                  async_wptr_o,
   output logic [2**LOG_DEPTH-1:0][DW-1:0]     async_data_o,
   input  logic [LOG_DEPTH:0]                  async_rptr_i,
   output logic                                full_o,
   output logic [LOG_DEPTH:0]                  fill_o,
   output logic [15:0]                         drop_cnt_o,
   input  logic                                clr_drop_i
);
   localparam int DEPTH = 2**LOG_DEPTH;

   logic [LOG_DEPTH:0]                   wbin, wbin_n, rbin_s;
   logic [SYNC_STAGES-1:0][LOG_DEPTH:0]  rsync;
   logic [2*N_CH-1:0]                    rot;
   logic [N_CH-1:0]                      grant;
   logic [CH_IDW-1:0]                    rr, gidx, rr_n;
   logic                                 found, hs, wr, drop;

   assign wbin_n = wbin + 1'b1;
   assign fill_o = wbin - rbin_s;
   assign full_o = fill_o == (LOG_DEPTH+1)'(DEPTH);
   assign rot    = {evt_valid_i, evt_valid_i} >> rr;
   assign grant  = found ? N_CH'(1) << gidx : '0;
   assign rr_n   = (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
   assign hs     = found & (DROP_ON_FULL | ~full_o);
   assign wr     = hs & ~full_o;
   assign drop   = hs & full_o;
   assign evt_ready_o = (full_o & ~DROP_ON_FULL) ? '0 : grant;

   // gray to binary of the last synchroniser stage: bit i is the xor of all bits at or above i
   always_comb begin
      rbin_s = '0;
      for (int i = 0; i <= LOG_DEPTH; i++) rbin_s[i] = ^(rsync[SYNC_STAGES-1] >> i);
   end

   // round-robin search: first valid channel at or after rr, wrapping
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            gidx  = CH_IDW'((int'(rr) + k) % N_CH);
         end
      end
   end

   // read-pointer synchroniser chain from the consumer domain
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) rsync <= '0;
      else         rsync <= {rsync[SYNC_STAGES-2:0], async_rptr_i};

   // storage, binary/gray write pointers and arbiter state; data and pointer move on the same edge
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         wbin         <= '0;
         async_wptr_o <= '0;
         async_data_o <= '0;
         rr           <= '0;
      end else begin
         if (wr) begin
            async_data_o[wbin[LOG_DEPTH-1:0]] <= {gidx, evt_data_i[gidx]};
            wbin         <= wbin_n;
            async_wptr_o <= wbin_n ^ (wbin_n >> 1);
         end
         if (hs) rr <= rr_n;
      end

   // saturating drop counter; clear wins over a same-cycle drop
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni)                           drop_cnt_o <= '0;
      else if (clr_drop_i)                   drop_cnt_o <= '0;
      else if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 1'b1;
endmodule

// File: tb/tb_soc_event_async_src.sv
// tb_soc_event_async_src: table and scoreboard checks of the async event FIFO write half
module tb_soc_event_async_src;
   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       valid, ready, wptr, rptr, fill;
   logic [3:0][7:0]  data;
   logic [7:0][9:0]  adata;
   logic             full, clr;
   logic [15:0]      dcnt;
   logic [1:0]       dvalid, dready;
   logic [1:0][7:0]  ddata;
   logic [3:0]       dwptr, drptr, dfill;
   logic [7:0][8:0]  dadata;
   logic             dfull, dclr;
   logic [15:0]      ddcnt;

   int checks = 0;
   int errors = 0;
   logic [3:0] wcount, rd_q0, rd_q1;
   int ccnt[4];

   typedef struct {logic [2:0] slot; logic [1:0] tag; logic [7:0] data;} sb_t;
   sb_t sb[$];
   typedef struct {logic [3:0] vld; logic [3:0] rdy; logic [3:0] wptr; logic [3:0] fill; logic full;} vec_t;
   vec_t tbl[9];
   logic [3:0] gseq[9] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd12};

   soc_event_async_src u_dut (
      .clk_i(clk), .rst_ni(rst_n), .evt_valid_i(valid), .evt_data_i(data),
      .evt_ready_o(ready), .async_wptr_o(wptr), .async_data_o(adata),
      .async_rptr_i(rptr), .full_o(full), .fill_o(fill), .drop_cnt_o(dcnt),
      .clr_drop_i(clr));

   soc_event_async_src #(.N_CH(2), .DROP_ON_FULL(1'b1)) u_drp (
      .clk_i(clk), .rst_ni(rst_n), .evt_valid_i(dvalid), .evt_data_i(ddata),
      .evt_ready_o(dready), .async_wptr_o(dwptr), .async_data_o(dadata),
      .async_rptr_i(drptr), .full_o(dfull), .fill_o(dfill), .drop_cnt_o(ddcnt),
      .clr_drop_i(dclr));

   always #5 clk = ~clk;

   function automatic logic [3:0] gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // one cycle on the main instance; expected slot contents go to the scoreboard on acceptance
   task automatic step_main(input logic [3:0] vld, input logic [3:0] rdy, input logic [3:0] rb);
      int   c;
      sb_t  e;
      valid = vld;
      rptr  = gray(rb);
      rd_q1 = rd_q0;
      rd_q0 = rb;
      for (int i = 0; i < 4; i++) data[i] = 8'(i * 64 + ccnt[i]);
      #1;
      chk("ready", 32'(ready), 32'(rdy));
      if (rdy != 4'd0) begin
         c = 0;
         for (int i = 0; i < 4; i++) if (rdy[i]) c = i;
         sb.push_back('{wcount[2:0], 2'(c), data[c]});
         wcount++;
         ccnt[c]++;
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk("slot", 32'(adata[e.slot]), 32'({e.tag, e.data}));
      end
      chk("wptr", 32'(wptr), 32'(gray(wcount)));
      chk("fill", 32'(fill), 32'(4'(wcount - rd_q1)));
   endtask

   // one cycle on the drop-mode instance, channel 1 only
   task automatic step_drp(input logic [1:0] rdy, input logic c, input logic [15:0] cnt,
                           input logic [3:0] wp, input logic f, input logic [7:0] pay);
      dvalid   = 2'b10;
      ddata[1] = pay;
      dclr     = c;
      #1;
      chk("d_ready", 32'(dready), 32'(rdy));
      @(posedge clk);
      #1;
      chk("d_wptr", 32'(dwptr), 32'(wp));
      chk("d_drop", 32'(ddcnt), 32'(cnt));
      chk("d_full", 32'(dfull), 32'(f));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 9; i++)
         tbl[i] = '{4'b0001, (i < 8) ? 4'b0001 : 4'b0000, gseq[i], (i < 8) ? 4'(i + 1) : 4'd8, i >= 7};
      rst_n = 1'b0; valid = '0; data = '0; rptr = '0; clr = 1'b0;
      dvalid = '0; ddata = '0; drptr = '0; dclr = 1'b0;
      wcount = '0; rd_q0 = '0; rd_q1 = '0;
      for (int i = 0; i < 4; i++) ccnt[i] = 0;
      #3;
      chk("rst_wptr", 32'(wptr), 0);
      chk("rst_fill", 32'(fill), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_drop", 32'(ddcnt), 0);
      #20;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      // fill to full on channel 0 with the consumer idle
      for (int i = 0; i < 9; i++) begin
         step_main(tbl[i].vld, tbl[i].rdy, 4'd0);
         chk("tbl_wptr", 32'(wptr), 32'(tbl[i].wptr));
         chk("tbl_fill", 32'(fill), 32'(tbl[i].fill));
         chk("tbl_full", 32'(full), 32'(tbl[i].full));
      end
      // consumer reads three: visible only after the synchroniser
      step_main(4'd0, 4'd0, 4'd3);
      chk("drain_stale_full", 32'(full), 1);
      step_main(4'd0, 4'd0, 4'd3);
      chk("drain_full", 32'(full), 0);
      valid = 4'b0001;
      #1;
      chk("drain_ready", 32'(ready), 1);
      valid = 4'b0000;
      // drop mode: fill, three drops, clear with a drop, one more drop
      for (int i = 0; i < 8; i++) step_drp(2'b10, 1'b0, 16'd0, gseq[i], i == 7, 8'(8'h50 + i));
      for (int i = 0; i < 3; i++) step_drp(2'b10, 1'b0, 16'(i + 1), 4'd12, 1'b1, 8'(8'h58 + i));
      step_drp(2'b10, 1'b1, 16'd0, 4'd12, 1'b1, 8'h5B);
      step_drp(2'b10, 1'b0, 16'd1, 4'd12, 1'b1, 8'h5C);
      dvalid = 2'b00;
      chk("d_slot0", 32'(dadata[0]), 32'(9'h150));
      chk("d_slot7", 32'(dadata[7]), 32'(9'h157));
      // reset mid-burst, asserted between clock edges
      step_main(4'b0001, 4'b0001, 4'd3);
      step_main(4'b0001, 4'b0001, 4'd3);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      rptr  = '0;
      #1;
      chk("mid_wptr", 32'(wptr), 0);
      chk("mid_fill", 32'(fill), 0);
      chk("mid_full", 32'(full), 0);
      chk("mid_ready", 32'(ready), 1);
      chk("mid_slot1", 32'(adata[1]), 0);
      chk("mid_dwptr", 32'(dwptr), 0);
      chk("mid_ddrop", 32'(ddcnt), 0);
      valid = '0;
      wcount = '0; rd_q0 = '0; rd_q1 = '0;
      for (int i = 0; i < 4; i++) ccnt[i] = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      // fairness: all channels valid, consumer tracking the writer
      for (int k = 0; k < 12; k++) step_main(4'hF, 4'(1 << (k % 4)), wcount);
      // wrap: channel 2 only, consumer trailing by two
      for (int k = 0; k < 40; k++) step_main(4'b0100, 4'b0100, 4'(wcount - 4'd2));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
